serial_comparator_framed: RTL and testbench

SERIAL_COMPARATOR_FRAMED -- requirements
Module: serial_comparator_framed

---
 rtl/serial_cmp_pkg.sv | 51 +++++
 rtl/serial_comparator_framed_if.sv | 42 ++++
 rtl/serial_cmp_digit_rel.sv | 52 +++++
 rtl/serial_comparator_framed.sv | 124 ++++++++++++
 tb/tb_serial_comparator_framed.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared types and helpers for the framed serial comparator.
//   rel_t          : relation of a against b (equal / less / greater)
//   state_t        : comparator FSM state; ST_IDLE means no frame is open
//   rel_to_state   : map a relation onto its open-frame state
//   state_to_rel   : relation held by an open-frame state
//   fold_rel       : combine the running relation with a new digit's relation
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EQ   = 2'd1,
    ST_LT   = 2'd2,
    ST_GT   = 2'd3
  } state_t;

  function automatic state_t rel_to_state(input rel_t r);
    case (r)
      REL_LT:  return ST_LT;
      REL_GT:  return ST_GT;
      default: return ST_EQ;
    endcase
  endfunction

  function automatic rel_t state_to_rel(input state_t s);
    case (s)
      ST_LT:   return REL_LT;
      ST_GT:   return REL_GT;
      default: return REL_EQ;
    endcase
  endfunction

  // MSB-first: the first differing digit decides, later digits cannot change it.
  // LSB-first: the most recent differing digit is the most significant one seen
  // so far, so it overwrites. Starting a frame from REL_EQ works for both orders.
  function automatic rel_t fold_rel(input rel_t cur, input rel_t dig, input logic msb_first);
    if (msb_first) begin
      return (cur == REL_EQ) ? dig : cur;
    end
    return (dig == REL_EQ) ? cur : dig;
  endfunction

endpackage

// File: rtl/serial_comparator_framed_if.sv
// -----------------------------------------------------------------------------
// serial_comparator_framed_if
// Beat stream into the comparator and frame result out of it.
//   Parameters: DIGIT_W (bits per beat), MAX_BEATS (beat counter saturation).
//   Stream side : msb_first, in_valid, in_last, a, b
//   Result side : out_valid, a_less_b, a_eq_b, a_greater_b, beat_count, overflow
// Handshake: a beat is any cycle with in_valid=1; there is no ready, the block
// accepts every beat. in_valid=0 is a stall and changes nothing. out_valid is a
// single-cycle pulse; the result fields are registered and hold between pulses.
// modport master : the producer of beats / consumer of results
// modport slave  : the comparator
// -----------------------------------------------------------------------------
interface serial_comparator_framed_if #(
  parameter int DIGIT_W   = 1,
  parameter int MAX_BEATS = 32
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic               msb_first;
  logic               in_valid;
  logic               in_last;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;

  logic               out_valid;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;
  logic [CW-1:0]      beat_count;
  logic               overflow;

  modport master (
    output msb_first, in_valid, in_last, a, b,
    input  out_valid, a_less_b, a_eq_b, a_greater_b, beat_count, overflow
  );

  modport slave (
    input  msb_first, in_valid, in_last, a, b,
    output out_valid, a_less_b, a_eq_b, a_greater_b, beat_count, overflow
  );

endinterface

// File: rtl/serial_cmp_digit_rel.sv
// -----------------------------------------------------------------------------
// serial_cmp_digit_rel
// Combinational relation of one digit pair.
//   a_i, b_i      : operand digits (DIGIT_W bits)
//   invert_msb_i  : digit carries the sign; flip its top bit before comparing
//   rel_o         : REL_EQ / REL_LT / REL_GT
// Build option SERIAL_COMPARATOR_SIGNED_EN enables the sign-bit flip; without it
// the flag is ignored and the comparison is plain unsigned.
// -----------------------------------------------------------------------------
module serial_cmp_digit_rel
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               invert_msb_i,
  output rel_t               rel_o
);

  logic [DIGIT_W-1:0] a_eff;
  logic [DIGIT_W-1:0] b_eff;

`ifdef SERIAL_COMPARATOR_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  logic [DIGIT_W-1:0] msb_mask;

  always_comb begin
    msb_mask              = '0;
    msb_mask[DIGIT_W-1]   = invert_msb_i;
  end

  assign a_eff = a_i ^ msb_mask;
  assign b_eff = b_i ^ msb_mask;
`else
  logic unused_invert_msb;

  assign unused_invert_msb = invert_msb_i;
  assign a_eff             = a_i;
  assign b_eff             = b_i;
`endif

  always_comb begin
    rel_o = REL_EQ;
    if (a_eff < b_eff) begin
      rel_o = REL_LT;
    end else if (a_eff > b_eff) begin
      rel_o = REL_GT;
    end
  end

endmodule

// File: rtl/serial_comparator_framed.sv
// -----------------------------------------------------------------------------
// serial_comparator_framed
// Compares two operands delivered DIGIT_W bits per beat over a framed stream and
// reports the relation one cycle after the frame's last beat.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_comparator_framed_if.slave (beats in, frame result out)
//   state_o  : current FSM state, for observation
// Parameters: DIGIT_W (bits per beat), MAX_BEATS (beat_count saturation point;
// a frame longer than this reports overflow but still compares every beat).
// Build option SERIAL_COMPARATOR_SIGNED_EN: compare as two's complement.
// -----------------------------------------------------------------------------
module serial_comparator_framed
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W   = 1,
  parameter int MAX_BEATS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_comparator_framed_if.slave    bus,
  output state_t                       state_o
);

  localparam int            CW      = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  // Frame tracking
  state_t        state_q, state_d;
  logic          msb_q, msb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  // Registered frame result
  logic          out_valid_q;
  logic          lt_q, eq_q, gt_q;
  logic [CW-1:0] bc_q;
  logic          bc_ovf_q;

  logic          first_beat;
  logic          beat_msb;
  logic          invert_msb;
  rel_t          dig_rel;
  rel_t          cur_rel;
  rel_t          rel_d;

  // Order is taken from the first beat only; later beats use the latched copy.
  assign first_beat = (state_q == ST_IDLE);
  assign beat_msb   = first_beat ? bus.msb_first : msb_q;

`ifdef SERIAL_COMPARATOR_SIGNED_EN
  // The sign digit is the first beat in MSB-first order and the last beat in
  // LSB-first order; a single-beat frame is both, which is still one digit.
  assign invert_msb = (first_beat & beat_msb) | (bus.in_last & ~beat_msb);
`else
  assign invert_msb = 1'b0;
`endif

  serial_cmp_digit_rel #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_rel (
    .a_i          (bus.a),
    .b_i          (bus.b),
    .invert_msb_i (invert_msb),
    .rel_o        (dig_rel)
  );

  always_comb begin
    cur_rel = first_beat ? REL_EQ : state_to_rel(state_q);
    rel_d   = fold_rel(cur_rel, dig_rel, beat_msb);
    msb_d   = beat_msb;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (first_beat) begin
      cnt_d = CW'(1);
      ovf_d = 1'b0;
    end else if (cnt_q == MAX_CNT) begin
      // Counter already saturated: this beat is past the supported length.
      ovf_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    state_d = bus.in_last ? ST_IDLE : rel_to_state(rel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      msb_q       <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      bc_q        <= '0;
      bc_ovf_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        state_q <= state_d;
        msb_q   <= msb_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
        if (bus.in_last) begin
          out_valid_q <= 1'b1;
          lt_q        <= (rel_d == REL_LT);
          eq_q        <= (rel_d == REL_EQ);
          gt_q        <= (rel_d == REL_GT);
          bc_q        <= cnt_d;
          bc_ovf_q    <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.a_less_b    = lt_q;
  assign bus.a_eq_b      = eq_q;
  assign bus.a_greater_b = gt_q;
  assign bus.beat_count  = bc_q;
  assign bus.overflow    = bc_ovf_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_serial_comparator_framed.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator_framed
// Two comparator instances: u_w4 (DIGIT_W=4, MAX_BEATS=4) and u_w1 (DIGIT_W=1,
// MAX_BEATS=32). Expected results come from a whole-operand model and are queued
// when a frame is driven; monitors pop them on out_valid.
// -----------------------------------------------------------------------------
module tb_serial_comparator_framed;
  import serial_cmp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_comparator_framed_if #(.DIGIT_W(4), .MAX_BEATS(4))  bus4 ();
  serial_comparator_framed_if #(.DIGIT_W(1), .MAX_BEATS(32)) bus1 ();
  state_t state4;
  state_t state1;

  serial_comparator_framed #(.DIGIT_W(4), .MAX_BEATS(4)) u_w4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus4.slave),
    .state_o (state4)
  );

  serial_comparator_framed #(.DIGIT_W(1), .MAX_BEATS(32)) u_w1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1.slave),
    .state_o (state1)
  );

  // ---------------- scoreboard ----------------
  // Entry: {lt, eq, gt, overflow, beat_count[7:0]}
  logic [11:0] exp_q4[$];
  logic [11:0] exp_q1[$];
  int          errors  = 0;
  int          checks  = 0;
  int          pulses4 = 0;
  int          pulses1 = 0;

  function automatic logic [11:0] model(input int n, input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input int maxb);
    int          bits;
    logic [63:0] mask;
    logic [63:0] ua, ub;
    logic        lt, eq, gt, ovf;
    int          cnt;
    bits = n * w;
    mask = (64'd1 << bits) - 64'd1;
    ua   = av & mask;
    ub   = bv & mask;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    begin
      longint sa, sb;
      sa = longint'(ua << (64 - bits)) >>> (64 - bits);
      sb = longint'(ub << (64 - bits)) >>> (64 - bits);
      lt = (sa < sb);
      gt = (sa > sb);
    end
`else
    lt = (ua < ub);
    gt = (ua > ub);
`endif
    eq  = !lt && !gt;
    cnt = (n > maxb) ? maxb : n;
    ovf = (n > maxb);
    return {lt, eq, gt, ovf, 8'(cnt)};
  endfunction

  // ---------------- monitors ----------------
  logic        exp_pulse4;
  logic [11:0] hold4 = '0;
  logic [11:0] got4;
  logic [11:0] e4;

  always begin
    @(posedge clk);
    exp_pulse4 = !rst && (bus4.in_valid === 1'b1) && (bus4.in_last === 1'b1);
    if (rst) hold4 = '0;
    @(negedge clk);
    got4 = {bus4.a_less_b, bus4.a_eq_b, bus4.a_greater_b, bus4.overflow, 8'(bus4.beat_count)};
    checks++;
    if (bus4.out_valid !== exp_pulse4) begin
      errors++;
      $display("FAIL w4_out_valid t=%0t got=%b exp=%b", $time, bus4.out_valid, exp_pulse4);
    end
    if (bus4.out_valid === 1'b1) begin
      pulses4++;
      checks++;
      if (exp_q4.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected_result t=%0t got=%h exp=<none>", $time, got4);
      end else begin
        e4    = exp_q4.pop_front();
        hold4 = e4;
        if (got4 !== e4) begin
          errors++;
          $display("FAIL w4_result t=%0t got=%h exp=%h", $time, got4, e4);
        end
      end
    end else begin
      checks++;
      if (got4 !== hold4) begin
        errors++;
        $display("FAIL w4_hold t=%0t got=%h exp=%h", $time, got4, hold4);
      end
    end
  end

  logic        exp_pulse1;
  logic [11:0] hold1 = '0;
  logic [11:0] got1;
  logic [11:0] e1;

  always begin
    @(posedge clk);
    exp_pulse1 = !rst && (bus1.in_valid === 1'b1) && (bus1.in_last === 1'b1);
    if (rst) hold1 = '0;
    @(negedge clk);
    got1 = {bus1.a_less_b, bus1.a_eq_b, bus1.a_greater_b, bus1.overflow, 8'(bus1.beat_count)};
    checks++;
    if (bus1.out_valid !== exp_pulse1) begin
      errors++;
      $display("FAIL w1_out_valid t=%0t got=%b exp=%b", $time, bus1.out_valid, exp_pulse1);
    end
    if (bus1.out_valid === 1'b1) begin
      pulses1++;
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL w1_unexpected_result t=%0t got=%h exp=<none>", $time, got1);
      end else begin
        e1    = exp_q1.pop_front();
        hold1 = e1;
        if (got1 !== e1) begin
          errors++;
          $display("FAIL w1_result t=%0t got=%h exp=%h", $time, got1, e1);
        end
      end
    end else begin
      checks++;
      if (got1 !== hold1) begin
        errors++;
        $display("FAIL w1_hold t=%0t got=%h exp=%h", $time, got1, hold1);
      end
    end
  end

  // ---------------- drivers ----------------
  // Beats are driven 1 time unit after a rising edge; stall cycles carry junk data
  // and mid-frame msb_first is randomised since it must be ignored.
  task automatic frame4(input int n, input logic [63:0] av, input logic [63:0] bv,
                        input logic msb, input int max_stall);
    exp_q4.push_back(model(n, 4, av, bv, 4));
    for (int i = 0; i < n; i++) begin
      int idx;
      int st;
      idx = msb ? (n - 1 - i) : i;
      st  = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      for (int s = 0; s < st; s++) begin
        bus4.in_valid  = 1'b0;
        bus4.in_last   = 1'($urandom);
        bus4.a         = 4'($urandom);
        bus4.b         = 4'($urandom);
        bus4.msb_first = 1'($urandom);
        @(posedge clk); #1;
      end
      bus4.in_valid  = 1'b1;
      bus4.in_last   = (i == n - 1);
      bus4.a         = 4'(av >> (4 * idx));
      bus4.b         = 4'(bv >> (4 * idx));
      bus4.msb_first = (i == 0) ? msb : 1'($urandom);
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    bus4.in_last  = 1'b0;
  endtask

  task automatic frame1(input int n, input logic [63:0] av, input logic [63:0] bv,
                        input logic msb, input int max_stall);
    exp_q1.push_back(model(n, 1, av, bv, 32));
    for (int i = 0; i < n; i++) begin
      int idx;
      int st;
      idx = msb ? (n - 1 - i) : i;
      st  = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      for (int s = 0; s < st; s++) begin
        bus1.in_valid  = 1'b0;
        bus1.in_last   = 1'($urandom);
        bus1.a         = 1'($urandom);
        bus1.b         = 1'($urandom);
        bus1.msb_first = 1'($urandom);
        @(posedge clk); #1;
      end
      bus1.in_valid  = 1'b1;
      bus1.in_last   = (i == n - 1);
      bus1.a         = 1'(av >> idx);
      bus1.b         = 1'(bv >> idx);
      bus1.msb_first = (i == 0) ? msb : 1'($urandom);
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus4.out_valid, bus4.a_less_b, bus4.a_eq_b, bus4.a_greater_b, bus4.beat_count, bus4.overflow} !== '0
        || state4 !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_w4 got_state=%0d got_eq=%b exp=all zero/idle", state4, bus4.a_eq_b);
    end
    checks++;
    if ({bus1.out_valid, bus1.a_less_b, bus1.a_eq_b, bus1.a_greater_b, bus1.beat_count, bus1.overflow} !== '0
        || state1 !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_w1 got_state=%0d got_eq=%b exp=all zero/idle", state1, bus1.a_eq_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_msb_first;
    frame4(2, 64'h3A, 64'h3B, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.a_less_b !== 1'b1 || bus4.beat_count !== 3'd2) begin
      errors++;
      $display("FAIL msb_first got v=%b lt=%b cnt=%0d exp v=1 lt=1 cnt=2",
               bus4.out_valid, bus4.a_less_b, bus4.beat_count);
    end
    checks++;
    if (state4 !== ST_IDLE) begin
      errors++;
      $display("FAIL msb_first_idle got=%0d exp=%0d", state4, ST_IDLE);
    end
  endtask

  task automatic test_lsb_first;
    frame4(2, 64'h12, 64'h21, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.a_less_b !== 1'b1) begin
      errors++;
      $display("FAIL lsb_first got v=%b lt=%b exp v=1 lt=1", bus4.out_valid, bus4.a_less_b);
    end
  endtask

  task automatic test_signed;
    logic exp_lt;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    exp_lt = 1'b1;
`else
    exp_lt = 1'b0;
`endif
    frame4(2, 64'hF0, 64'h10, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (bus4.a_less_b !== exp_lt || bus4.a_greater_b !== !exp_lt) begin
      errors++;
      $display("FAIL signed_cmp got lt=%b gt=%b exp lt=%b gt=%b",
               bus4.a_less_b, bus4.a_greater_b, exp_lt, !exp_lt);
    end
    // Sign digit at the end of an LSB-first frame
    frame4(2, 64'h90, 64'h10, 1'b0, 1);
    frame4(1, 64'h2, 64'h9, 1'b1, 0);
  endtask

  task automatic test_stall_equal;
    int p0;
    p0 = pulses1;
    frame1(8, 64'hA5, 64'hA5, 1'b1, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pulses1 - p0 !== 1 || bus1.a_eq_b !== 1'b1 || bus1.beat_count !== 6'd8) begin
      errors++;
      $display("FAIL stall_equal got pulses=%0d eq=%b cnt=%0d exp pulses=1 eq=1 cnt=8",
               pulses1 - p0, bus1.a_eq_b, bus1.beat_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    frame4(6, 64'h700301, 64'h500302, 1'b0, 1);
    @(negedge clk);
    checks++;
    if (bus4.a_greater_b !== 1'b1 || bus4.beat_count !== 3'd4 || bus4.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow got gt=%b cnt=%0d ovf=%b exp gt=1 cnt=4 ovf=1",
               bus4.a_greater_b, bus4.beat_count, bus4.overflow);
    end
    @(posedge clk); #1;
    frame4(3, 64'h123, 64'h123, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (bus4.overflow !== 1'b0 || bus4.a_eq_b !== 1'b1 || bus4.beat_count !== 3'd3) begin
      errors++;
      $display("FAIL overflow_clear got ovf=%b eq=%b cnt=%0d exp ovf=0 eq=1 cnt=3",
               bus4.overflow, bus4.a_eq_b, bus4.beat_count);
    end
    @(posedge clk); #1;
    frame4(4, 64'h8000, 64'h7FFF, 1'b1, 0);
    frame4(5, 64'h00001, 64'h00002, 1'b0, 0);
    frame1(40, 64'hFF_0000_0001, 64'hFF_0000_0000, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 12; k++) begin
      int          n;
      logic [63:0] av, bv;
      n  = int'($urandom_range(6, 1));
      av = {32'($urandom), 32'($urandom)};
      bv = ($urandom_range(2, 0) == 0) ? av : {32'($urandom), 32'($urandom)};
      frame4(n, av, bv, 1'($urandom), 0);
    end
    for (int k = 0; k < 8; k++) begin
      int          n;
      logic [63:0] av, bv;
      n  = int'($urandom_range(36, 1));
      av = {32'($urandom), 32'($urandom)};
      bv = ($urandom_range(2, 0) == 0) ? av : (av ^ (64'd1 << $urandom_range(n - 1, 0)));
      frame1(n, av, bv, 1'($urandom), k % 2);
    end
  endtask

  task automatic test_single_beat;
    frame4(1, 64'h7, 64'h7, 1'b0, 0);
    frame4(1, 64'h3, 64'h1, 1'b1, 0);
    frame1(1, 64'h0, 64'h1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    repeat (2) @(posedge clk); #1;
    p0 = pulses4;
    // beat 1 of a three-beat frame
    bus4.in_valid = 1'b1; bus4.in_last = 1'b0; bus4.msb_first = 1'b1;
    bus4.a = 4'h1; bus4.b = 4'h2;
    @(posedge clk); #1;
    // beat 2 coincides with reset
    rst = 1'b1; bus4.a = 4'h3; bus4.b = 4'h3;
    @(posedge clk); #1;
    rst = 1'b0; bus4.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state4 !== ST_IDLE || bus4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame_idle got state=%0d v=%b exp state=0 v=0", state4, bus4.out_valid);
    end
    @(posedge clk); #1;
    frame4(1, 64'h5, 64'h5, 1'b1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pulses4 - p0 !== 1 || bus4.a_eq_b !== 1'b1 || bus4.beat_count !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid_frame got pulses=%0d eq=%b cnt=%0d exp pulses=1 eq=1 cnt=1",
               pulses4 - p0, bus4.a_eq_b, bus4.beat_count);
    end
    // Reset beats a simultaneous last beat
    @(posedge clk); #1;
    p0 = pulses4;
    bus4.in_valid = 1'b1; bus4.in_last = 1'b1; bus4.a = 4'h9; bus4.b = 4'h1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus4.in_valid = 1'b0; bus4.in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pulses4 - p0 !== 0) begin
      errors++;
      $display("FAIL reset_vs_last got pulses=%0d exp pulses=0", pulses4 - p0);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus4.in_valid = 1'b0; bus4.in_last = 1'b0; bus4.msb_first = 1'b1; bus4.a = '0; bus4.b = '0;
    bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.msb_first = 1'b1; bus1.a = '0; bus1.b = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_signed();
    test_stall_equal();
    test_overflow();
    test_single_beat();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q4.size() != 0) begin
      errors++;
      $display("FAIL w4_drain got=%0d pending exp=0", exp_q4.size());
    end
    checks++;
    if (exp_q1.size() != 0) begin
      errors++;
      $display("FAIL w1_drain got=%0d pending exp=0", exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
